// File: rtl/serial_tx_pkg.sv
// Shared types and line levels for the serial transmitter.
// Optional parity stage is enabled by SERIAL_TX_PARITY_EN.
package serial_tx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    localparam logic START_BIT  = 1'b0;
    localparam logic STOP_BIT   = 1'b1;
    localparam logic IDLE_LEVEL = 1'b1;

    // Counter width for 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/baud_tick_gen.sv
// Bit-period counter: bit_end pulses on the last cycle of each bit.
// Held at zero while clear is high; shared with the receiver side.
module baud_tick_gen
    import serial_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clockpulse,
    input  logic preset,
    input  logic clear,
    output logic bit_end
);

    localparam int CW = cnt_width(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt;

    // Count 0..CLKS_PER_BIT-1 and wrap; clear restarts the bit period.
    always_ff @(posedge clockpulse or posedge preset) begin
        if (preset) begin
            cnt <= '0;
        end else if (clear || cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    assign bit_end = !clear && (cnt == LAST);

endmodule

// File: rtl/serial_tx_shifter.sv
// LSB-first frame transmitter: start, data, [parity], stop.
// Define SERIAL_TX_PARITY_EN to insert an even-parity bit.
module serial_tx_shifter
    import serial_tx_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic                  clockpulse,
    input  logic                  preset,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  data_valid,
    output logic                  data_ready,
    output logic                  txout,
    output logic                  nottxout,
    output logic                  busy,
    output logic                  done
);

    localparam int IW = cnt_width(DATA_WIDTH);
    localparam logic [IW-1:0] LAST_BIT = IW'(DATA_WIDTH - 1);

    tx_state_t             state, state_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic                  tx_q, tx_d;
    logic                  bit_end;
    logic                  baud_clear;
    logic                  accept;
`ifdef SERIAL_TX_PARITY_EN
    logic                  par_q, par_d;
`endif

    assign baud_clear = (state == IDLE);
    assign data_ready = (state == IDLE);
    assign busy       = (state != IDLE);
    assign accept     = data_valid && data_ready;
    assign done       = (state == STOP) && bit_end;
    assign txout      = tx_q;
    assign nottxout   = ~tx_q;

    baud_tick_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clockpulse(clockpulse),
        .preset    (preset),
        .clear     (baud_clear),
        .bit_end   (bit_end)
    );

    // State, datapath and the registered line level.
    always_ff @(posedge clockpulse or posedge preset) begin
        if (preset) begin
            state   <= IDLE;
            shift_q <= '0;
            idx_q   <= '0;
            tx_q    <= IDLE_LEVEL;
`ifdef SERIAL_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state   <= state_d;
            shift_q <= shift_d;
            idx_q   <= idx_d;
            tx_q    <= tx_d;
`ifdef SERIAL_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    // Next state, and the line level for the next state so txout is a flop.
    always_comb begin
        state_d = state;
        shift_d = shift_q;
        idx_d   = idx_q;
`ifdef SERIAL_TX_PARITY_EN
        par_d   = par_q;
`endif
        unique case (state)
            IDLE: begin
                if (accept) begin
                    state_d = START;
                    shift_d = data_in;
                    idx_d   = '0;
`ifdef SERIAL_TX_PARITY_EN
                    par_d   = ^data_in;
`endif
                end
            end
            START: begin
                if (bit_end) state_d = DATA;
            end
            DATA: begin
                if (bit_end) begin
                    shift_d = shift_q >> 1;
                    if (idx_q == LAST_BIT) begin
                        idx_d = '0;
`ifdef SERIAL_TX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end
            end
`ifdef SERIAL_TX_PARITY_EN
            PARITY: begin
                if (bit_end) state_d = STOP;
            end
`endif
            STOP: begin
                if (bit_end) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        tx_d = IDLE_LEVEL;
        unique case (state_d)
            IDLE:  tx_d = IDLE_LEVEL;
            START: tx_d = START_BIT;
            DATA:  tx_d = shift_d[0];
`ifdef SERIAL_TX_PARITY_EN
            PARITY: tx_d = par_d;
`endif
            STOP:  tx_d = STOP_BIT;
            default: tx_d = IDLE_LEVEL;
        endcase
    end

endmodule
